// File: rtl/secure_store_pkg.sv
//------------------------------------------------------------------------------
// Module   : secure_store_pkg
// Purpose  : Shared definitions for the secure bank store controller.
//            Contains the state encodings, the default password and the
//            helper functions used to size counters and the bank selector.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package secure_store_pkg;

  // State encoding. The gap at 010/011 is kept free on purpose because the
  // display logic decodes bit 2 as "busy / protected".
  localparam int unsigned c_STATE_W = 3;
  localparam logic [2:0] c_ST_IDLE    = 3'b000;
  localparam logic [2:0] c_ST_ACTIVE  = 3'b001;
  localparam logic [2:0] c_ST_LOCKOUT = 3'b100;
  localparam logic [2:0] c_ST_REQUEST = 3'b101;
  localparam logic [2:0] c_ST_STORE   = 3'b110;
  localparam logic [2:0] c_ST_ERROR   = 3'b111;

  // Default accepted password; zero-extended to the data width by users.
  localparam logic [3:0] c_DEFAULT_PASSWORD = 4'b1101;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Width of a counter that must hold 0 .. n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/secure_bank_store_if.sv
//------------------------------------------------------------------------------
// Module   : secure_bank_store_if
// Purpose  : Bundles the front-panel inputs and the readback/status outputs
//            of the secure bank store.
// Signals  : enable        - session enable (level)
//            confirm       - confirm button (level, edge-detected in the DUT)
//            pass_data     - password or data word, DATA_W bits
//            bank_data     - NUM_BANKS*DATA_W bank contents, bank i at
//                            [i*DATA_W +: DATA_W]
//            bank_valid    - bit i set once bank i has been written
//            current_state - 3-bit state encoding
//            fail_count    - consecutive wrong-password count
//            locked        - high while in lockout
//            store_pulse   - high for the single store cycle
// Modports : master - front panel / test driver
//            slave  - the controller
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface secure_bank_store_if #(
  parameter int DATA_W    = 4,
  parameter int NUM_BANKS = 2
);
  logic                          enable;
  logic                          confirm;
  logic [DATA_W-1:0]             pass_data;
  logic [NUM_BANKS*DATA_W-1:0]   bank_data;
  logic [NUM_BANKS-1:0]          bank_valid;
  logic [2:0]                    current_state;
  logic [3:0]                    fail_count;
  logic                          locked;
  logic                          store_pulse;

  modport master (
    output enable, confirm, pass_data,
    input  bank_data, bank_valid, current_state, fail_count, locked, store_pulse
  );

  modport slave (
    input  enable, confirm, pass_data,
    output bank_data, bank_valid, current_state, fail_count, locked, store_pulse
  );
endinterface

`default_nettype wire

// File: rtl/bank_register_file.sv
//------------------------------------------------------------------------------
// Module   : bank_register_file
// Purpose  : NUM_BANKS x DATA_W storage registers with a single write port.
//            Each bank carries a sticky valid bit set on its first write.
// Ports    : clk          - clock, rising edge
//            reset        - asynchronous active-high reset
//            i_we         - write enable
//            i_sel        - bank selector, SEL_W bits
//            i_wdata      - write data, DATA_W bits
//            o_bank_data  - flattened bank contents, bank i at [i*DATA_W +: DATA_W]
//            o_bank_valid - per-bank written flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bank_register_file #(
  parameter int DATA_W    = 4,
  parameter int NUM_BANKS = 2,
  parameter int SEL_W     = 1
) (
  input  wire logic                        clk,
  input  wire logic                        reset,
  input  wire logic                        i_we,
  input  wire logic [SEL_W-1:0]            i_sel,
  input  wire logic [DATA_W-1:0]           i_wdata,
  output logic      [NUM_BANKS*DATA_W-1:0] o_bank_data,
  output logic      [NUM_BANKS-1:0]        o_bank_valid
);

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_W-1:0] r_word;
    logic              r_valid;
    logic              w_hit;

    assign w_hit = i_we && (i_sel == SEL_W'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_word  <= '0;
        r_valid <= 1'b0;
      end else if (w_hit) begin
        r_word  <= i_wdata;
        r_valid <= 1'b1;
      end
    end

    assign o_bank_data[gi*DATA_W +: DATA_W] = r_word;
    assign o_bank_valid[gi]                 = r_valid;
  end

endmodule

`default_nettype wire

// File: rtl/secure_bank_store.sv
//------------------------------------------------------------------------------
// Module   : secure_bank_store
// Purpose  : Password-gated data capture controller. A confirmed correct
//            password opens a request window; the next confirmed word is
//            written into the bank chosen by its low SEL_W bits. Wrong
//            passwords are counted and MAX_TRIES in a row force a timed
//            lockout. The request window closes after TIMEOUT_CYCLES.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous active-high reset
//            bus   - secure_bank_store_if.slave (front-panel inputs,
//                    bank readback and status outputs)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module secure_bank_store
  import secure_store_pkg::*;
#(
  parameter int                DATA_W         = 4,
  parameter int                NUM_BANKS      = 2,
  parameter logic [DATA_W-1:0] PASSWORD       = DATA_W'(c_DEFAULT_PASSWORD),
  parameter int                MAX_TRIES      = 3,
  parameter int                LOCK_CYCLES    = 16,
  parameter int                TIMEOUT_CYCLES = 32
) (
  input wire logic              clk,
  input wire logic              reset,
  secure_bank_store_if.slave    bus
);

  localparam int c_SEL_W = int'(clog2(NUM_BANKS));
  localparam int c_TMR_W = int'(cnt_w(TIMEOUT_CYCLES));
  localparam int c_LCK_W = int'(cnt_w(LOCK_CYCLES));

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic                r_confirm_q;
  logic [3:0]          r_fail_count;
  logic [c_TMR_W-1:0]  r_timer;
  logic [c_LCK_W-1:0]  r_lock_timer;
  logic [DATA_W-1:0]   r_data_to_store;

  logic                w_confirm_evt;
  logic                w_pw_ok;
  logic [3:0]          w_fail_inc;
  logic                w_timeout_hit;
  logic                w_lock_done;
  logic                w_store;
  logic                w_locked;

  // A held button yields a single event on its rising edge.
  assign w_confirm_evt = bus.confirm & ~r_confirm_q;
  assign w_pw_ok       = (bus.pass_data == PASSWORD);
  assign w_fail_inc    = r_fail_count + 4'd1;
  assign w_timeout_hit = (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_lock_done   = (r_lock_timer == c_LCK_W'(LOCK_CYCLES - 1));

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic. Order of tests inside each state encodes priority:
  // lockout hold, then !enable, then confirm event, then timeout.
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.enable) w_next_state = c_ST_ACTIVE;
      end
      c_ST_ACTIVE: begin
        if (!bus.enable) begin
          w_next_state = c_ST_IDLE;
        end else if (w_confirm_evt) begin
          if (w_pw_ok)                         w_next_state = c_ST_REQUEST;
          else if (w_fail_inc == 4'(MAX_TRIES)) w_next_state = c_ST_LOCKOUT;
          else                                 w_next_state = c_ST_ERROR;
        end
      end
      c_ST_REQUEST: begin
        if (!bus.enable)        w_next_state = c_ST_IDLE;
        else if (w_confirm_evt) w_next_state = c_ST_STORE;
        else if (w_timeout_hit) w_next_state = c_ST_IDLE;
      end
      c_ST_STORE: begin
        w_next_state = c_ST_IDLE;
      end
      c_ST_ERROR: begin
        if (!bus.enable) w_next_state = c_ST_IDLE;
      end
      c_ST_LOCKOUT: begin
        // enable and confirm are deliberately not looked at here
        if (w_lock_done) w_next_state = c_ST_IDLE;
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Output decode (from registered state only)
  //--------------------------------------------------------------------------
  always_comb begin
    w_store  = 1'b0;
    w_locked = 1'b0;
    case (r_state)
      c_ST_STORE:   w_store  = 1'b1;
      c_ST_LOCKOUT: w_locked = 1'b1;
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath: edge detector, fail counter, request and lockout timers,
  // captured data word.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_confirm_q     <= 1'b0;
      r_fail_count    <= '0;
      r_timer         <= '0;
      r_lock_timer    <= '0;
      r_data_to_store <= '0;
    end else begin
      r_confirm_q <= bus.confirm;
      case (r_state)
        c_ST_ACTIVE: begin
          if (bus.enable && w_confirm_evt) begin
            if (w_pw_ok) begin
              r_fail_count <= '0;
              r_timer      <= '0;
            end else begin
              // Lock timer is primed on every miss; it only runs in lockout.
              r_fail_count <= w_fail_inc;
              r_lock_timer <= '0;
            end
          end
        end
        c_ST_REQUEST: begin
          if (bus.enable) begin
            if (w_confirm_evt)       r_data_to_store <= bus.pass_data;
            else if (!w_timeout_hit) r_timer         <= r_timer + c_TMR_W'(1);
          end
        end
        c_ST_LOCKOUT: begin
          if (w_lock_done) r_fail_count <= '0;
          else             r_lock_timer <= r_lock_timer + c_LCK_W'(1);
        end
        default: ;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Bank storage: written on the edge that leaves STORE.
  //--------------------------------------------------------------------------
  bank_register_file #(
    .DATA_W    (DATA_W),
    .NUM_BANKS (NUM_BANKS),
    .SEL_W     (c_SEL_W)
  ) u_banks (
    .clk          (clk),
    .reset        (reset),
    .i_we         (w_store),
    .i_sel        (r_data_to_store[c_SEL_W-1:0]),
    .i_wdata      (r_data_to_store),
    .o_bank_data  (bus.bank_data),
    .o_bank_valid (bus.bank_valid)
  );

  assign bus.current_state = r_state;
  assign bus.fail_count    = r_fail_count;
  assign bus.locked        = w_locked;
  assign bus.store_pulse   = w_store;

endmodule

`default_nettype wire

// File: tb/tb_secure_bank_store.sv
//------------------------------------------------------------------------------
// Module   : tb_secure_bank_store
// Purpose  : Self-checking bench for secure_bank_store. Two instances are
//            exercised: the default 4-bit / 2-bank build and an 8-bit /
//            4-bank build. Expected bank contents for every store are queued
//            by the stimulus and checked by a per-instance monitor when the
//            store pulse appears.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_secure_bank_store;
  import secure_store_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  secure_bank_store_if #(.DATA_W(4), .NUM_BANKS(2)) if0 ();
  secure_bank_store_if #(.DATA_W(8), .NUM_BANKS(4)) if1 ();

  secure_bank_store #(.DATA_W(4), .NUM_BANKS(2)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  secure_bank_store #(.DATA_W(8), .NUM_BANKS(4)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  typedef struct packed {
    logic [31:0] bank;
    logic [3:0]  valid;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic exp_t mk(input logic [31:0] b, input logic [3:0] v);
    exp_t e;
    e.bank  = b;
    e.valid = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One confirm press: high for one edge, low for the following edge.
  task automatic press0(input logic [3:0] v);
    if0.pass_data = v;
    if0.confirm   = 1'b1;
    @(posedge clk); #1;
    if0.confirm   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic press1(input logic [7:0] v);
    if1.pass_data = v;
    if1.confirm   = 1'b1;
    @(posedge clk); #1;
    if1.confirm   = 1'b0;
    @(posedge clk); #1;
  endtask

  //--------------------------------------------------------------------------
  // Store monitors
  //--------------------------------------------------------------------------
  initial begin : mon0
    exp_t e;
    forever begin
      @(negedge clk);
      if (if0.store_pulse === 1'b1) begin
        chk("d0_store_state", 32'(if0.current_state), 32'(c_ST_STORE));
        n_checks++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL d0_unexpected_store: got store_pulse 1 expected no store");
          e = mk(32'h0, 4'h0);
        end else begin
          e = q0.pop_front();
        end
        @(negedge clk);
        chk("d0_bank_data",  32'(if0.bank_data),     e.bank);
        chk("d0_bank_valid", 32'(if0.bank_valid),    32'(e.valid));
        chk("d0_pulse_once", 32'(if0.store_pulse),   32'h0);
        chk("d0_post_store", 32'(if0.current_state), 32'(c_ST_IDLE));
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (if1.store_pulse === 1'b1) begin
        chk("d1_store_state", 32'(if1.current_state), 32'(c_ST_STORE));
        n_checks++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL d1_unexpected_store: got store_pulse 1 expected no store");
          e = mk(32'h0, 4'h0);
        end else begin
          e = q1.pop_front();
        end
        @(negedge clk);
        chk("d1_bank_data",  if1.bank_data,           e.bank);
        chk("d1_bank_valid", 32'(if1.bank_valid),    32'(e.valid));
        chk("d1_pulse_once", 32'(if1.store_pulse),   32'h0);
        chk("d1_post_store", 32'(if1.current_state), 32'(c_ST_IDLE));
      end
    end
  end

  task automatic chk_all_zero0(input string tag);
    chk({tag, "_state"}, 32'(if0.current_state), 32'(c_ST_IDLE));
    chk({tag, "_bank"},  32'(if0.bank_data),     32'h0);
    chk({tag, "_valid"}, 32'(if0.bank_valid),    32'h0);
    chk({tag, "_fail"},  32'(if0.fail_count),    32'h0);
    chk({tag, "_lock"},  32'(if0.locked),        32'h0);
    chk({tag, "_store"}, 32'(if0.store_pulse),   32'h0);
  endtask

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    if0.enable = 1'b0; if0.confirm = 1'b0; if0.pass_data = '0;
    if1.enable = 1'b0; if1.confirm = 1'b0; if1.pass_data = '0;

    @(negedge clk);
    chk_all_zero0("rst");
    chk("rst_d1_state", 32'(if1.current_state), 32'(c_ST_IDLE));
    chk("rst_d1_bank",  if1.bank_data,          32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Happy path: password then data 0111 -> bank1
    if0.enable = 1'b1;
    step(1);
    @(negedge clk); chk("hp_active", 32'(if0.current_state), 32'(c_ST_ACTIVE));
    press0(4'b1101);
    @(negedge clk); chk("hp_request", 32'(if0.current_state), 32'(c_ST_REQUEST));
    q0.push_back(mk(32'h70, 4'b0010));
    press0(4'b0111);

    // Held confirm: one event only
    step(1);
    @(negedge clk); chk("held_active", 32'(if0.current_state), 32'(c_ST_ACTIVE));
    if0.pass_data = 4'b1101; if0.confirm = 1'b1;
    step(3);
    @(negedge clk); chk("held_request", 32'(if0.current_state), 32'(c_ST_REQUEST));
    if0.pass_data = 4'b0110;
    step(2);
    @(negedge clk); chk("held_no_store", 32'(if0.current_state), 32'(c_ST_REQUEST));
    if0.confirm = 1'b0;
    step(1);
    q0.push_back(mk(32'h76, 4'b0011));
    press0(4'b0110);

    // Wrong passwords and lockout
    step(1);
    @(negedge clk); chk("lk_active", 32'(if0.current_state), 32'(c_ST_ACTIVE));
    press0(4'b0000);
    @(negedge clk);
    chk("lk_err1_state", 32'(if0.current_state), 32'(c_ST_ERROR));
    chk("lk_err1_fail",  32'(if0.fail_count),    32'd1);
    press0(4'b0000);
    @(negedge clk);
    chk("lk_err_ignores_confirm", 32'(if0.current_state), 32'(c_ST_ERROR));
    chk("lk_err_fail_held",       32'(if0.fail_count),    32'd1);
    if0.enable = 1'b0;
    step(1);
    @(negedge clk);
    chk("lk_idle",           32'(if0.current_state), 32'(c_ST_IDLE));
    chk("lk_fail_kept_idle", 32'(if0.fail_count),    32'd1);
    if0.enable = 1'b1;
    step(1);
    press0(4'b0000);
    @(negedge clk);
    chk("lk_err2_state", 32'(if0.current_state), 32'(c_ST_ERROR));
    chk("lk_err2_fail",  32'(if0.fail_count),    32'd2);
    if0.enable = 1'b0; step(1);
    if0.enable = 1'b1; step(1);
    press0(4'b0000);
    @(negedge clk);   // lockout cycle 2
    chk("lk_state",  32'(if0.current_state), 32'(c_ST_LOCKOUT));
    chk("lk_locked", 32'(if0.locked),        32'd1);
    chk("lk_fail3",  32'(if0.fail_count),    32'd3);
    if0.enable = 1'b0;
    press0(4'b1101);
    @(negedge clk);   // lockout cycle 4
    chk("lk_ignores_inputs", 32'(if0.current_state), 32'(c_ST_LOCKOUT));
    step(12);
    @(negedge clk);   // lockout cycle 16
    chk("lk_last_cycle",  32'(if0.current_state), 32'(c_ST_LOCKOUT));
    chk("lk_last_locked", 32'(if0.locked),        32'd1);
    step(1);
    @(negedge clk);
    chk("lk_exit_state",  32'(if0.current_state), 32'(c_ST_IDLE));
    chk("lk_exit_locked", 32'(if0.locked),        32'd0);
    chk("lk_exit_fail",   32'(if0.fail_count),    32'd0);

    // Timeout with no confirm: REQUEST cycles 0..31, IDLE at 32
    if0.enable = 1'b1;
    step(1);
    press0(4'b1101);
    step(30);
    @(negedge clk); chk("to_cycle31", 32'(if0.current_state), 32'(c_ST_REQUEST));
    step(1);
    @(negedge clk);
    chk("to_idle",     32'(if0.current_state), 32'(c_ST_IDLE));
    chk("to_no_write", 32'(if0.bank_data),     32'h76);
    chk("to_valid",    32'(if0.bank_valid),    32'h3);

    // Confirm on the last timeout cycle wins
    step(1);
    press0(4'b1101);
    step(30);
    @(negedge clk); chk("to31_request", 32'(if0.current_state), 32'(c_ST_REQUEST));
    q0.push_back(mk(32'hB6, 4'b0011));
    press0(4'b1011);

    // Reset during REQUEST
    step(1);
    press0(4'b1101);
    @(negedge clk); chk("rr_request", 32'(if0.current_state), 32'(c_ST_REQUEST));
    reset = 1'b1;
    #2;
    chk_all_zero0("rr");
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset during LOCKOUT
    for (int i = 0; i < 3; i++) begin
      if0.enable = 1'b0; step(1);
      if0.enable = 1'b1; step(1);
      press0(4'b0000);
    end
    @(negedge clk); chk("rl_lockout", 32'(if0.current_state), 32'(c_ST_LOCKOUT));
    reset = 1'b1;
    #2;
    chk_all_zero0("rl");
    @(posedge clk); #1;
    reset = 1'b0;
    if0.enable = 1'b0;

    // Wide build: 8-bit data, four banks, password 8'h0D
    if1.enable = 1'b1;
    step(1);
    press1(8'h0D);
    @(negedge clk); chk("w_request", 32'(if1.current_state), 32'(c_ST_REQUEST));
    q1.push_back(mk(32'h00A6_0000, 4'b0100));
    press1(8'hA6);
    step(1);
    press1(8'h0D);
    q1.push_back(mk(32'h03A6_0000, 4'b1100));
    press1(8'h03);
    if1.enable = 1'b0;

    step(4);
    chk("d0_all_stores_seen", 32'(q0.size()), 32'h0);
    chk("d1_all_stores_seen", 32'(q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
